rf_wb_arbiter: RTL

//  Shares the single register-file write port between two writeback sources: ALU/execute (src 0) and load/store unit (src 1).

---
 rtl/rf_pkg.sv | 18 +
 rtl/rf_wb_hold.sv | 42 ++++
 rtl/rf_wb_arbiter.sv | 99 +++++++++
 3 files changed

// File: rtl/rf_pkg.sv
// Shared types and constants for the regfile writeback arbiter.
package rf_pkg;
    localparam int XLEN    = 64;
    localparam int RADDR_W = 5;

    // x0 is hardwired zero: writes to it are swallowed at the hold buffer.
    localparam logic [RADDR_W-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic [RADDR_W-1:0] rd;
        logic [XLEN-1:0]    data;
    } wb_req_t;

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_LSU = 1'b1
    } wb_src_e;
endpackage

// File: rtl/rf_wb_hold.sv
// One-entry writeback holding buffer with valid/ready on the input side.
// Requests that target x0 complete the handshake but are never stored.
module rf_wb_hold
    import rf_pkg::*;
(
    input  logic    clk,
    input  logic    reset,
    input  logic    i_valid,
    output logic    o_ready,
    input  wb_req_t i_req,
    input  logic    i_grant,
    output logic    o_hold_v,
    output wb_req_t o_req
);
    logic w_accept;
    logic w_store;

    // A granted entry leaves this cycle, so the slot can be refilled in the same cycle.
    assign o_ready  = !o_hold_v || i_grant;
    assign w_accept = i_valid && o_ready;
    assign w_store  = w_accept && (i_req.rd != REG_ZERO);

    // Buffer occupancy: refill takes priority over drain when both happen.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            o_hold_v <= 1'b0;
        end else if (w_store) begin
            o_hold_v <= 1'b1;
        end else if (i_grant) begin
            o_hold_v <= 1'b0;
        end
    end

    // Payload capture; no reset needed beyond keeping it deterministic.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            o_req <= '0;
        end else if (w_store) begin
            o_req <= i_req;
        end
    end
endmodule

// File: rtl/rf_wb_arbiter.sv
// Round-robin arbiter sharing the regfile write port between ALU (src 0)
// and LSU (src 1) writeback. Optional write-in-flight forwarding is built
// when RF_WB_FWD_EN is defined.
module rf_wb_arbiter
    import rf_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               alu_valid,
    output logic               alu_ready,
    input  logic [RADDR_W-1:0] alu_rd,
    input  logic [XLEN-1:0]    alu_data,
    input  logic               lsu_valid,
    output logic               lsu_ready,
    input  logic [RADDR_W-1:0] lsu_rd,
    input  logic [XLEN-1:0]    lsu_data,
`ifdef RF_WB_FWD_EN
    input  logic [RADDR_W-1:0] fwd_rs1,
    input  logic [RADDR_W-1:0] fwd_rs2,
    output logic               fwd_hit1,
    output logic               fwd_hit2,
    output logic [XLEN-1:0]    fwd_data1,
    output logic [XLEN-1:0]    fwd_data2,
`endif
    output logic               rf_reg_write,
    output logic [RADDR_W-1:0] rf_write_register,
    output logic [XLEN-1:0]    rf_write_data
);
    logic    w_alu_hold_v, w_lsu_hold_v;
    logic    w_alu_grant,  w_lsu_grant;
    wb_req_t w_alu_req,    w_lsu_req;
    wb_req_t w_win_req;
    wb_src_e r_rr;

    rf_wb_hold u_hold_alu (
        .clk      (clk),
        .reset    (reset),
        .i_valid  (alu_valid),
        .o_ready  (alu_ready),
        .i_req    ('{rd: alu_rd, data: alu_data}),
        .i_grant  (w_alu_grant),
        .o_hold_v (w_alu_hold_v),
        .o_req    (w_alu_req)
    );

    rf_wb_hold u_hold_lsu (
        .clk      (clk),
        .reset    (reset),
        .i_valid  (lsu_valid),
        .o_ready  (lsu_ready),
        .i_req    ('{rd: lsu_rd, data: lsu_data}),
        .i_grant  (w_lsu_grant),
        .o_hold_v (w_lsu_hold_v),
        .o_req    (w_lsu_req)
    );

    // Arbitration: a lone holder wins; on contention the rr pointer decides.
    always_comb begin
        w_alu_grant = w_alu_hold_v && (!w_lsu_hold_v || (r_rr == SRC_ALU));
        w_lsu_grant = w_lsu_hold_v && (!w_alu_hold_v || (r_rr == SRC_LSU));
        w_win_req   = w_alu_grant ? w_alu_req : w_lsu_req;
    end

    // Round-robin pointer: after a grant, favour the other source.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rr <= SRC_ALU;
        end else if (w_alu_grant) begin
            r_rr <= SRC_LSU;
        end else if (w_lsu_grant) begin
            r_rr <= SRC_ALU;
        end
    end

    // Registered write stage; index/data hold their last value when idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rf_reg_write      <= 1'b0;
            rf_write_register <= '0;
            rf_write_data     <= '0;
        end else begin
            rf_reg_write <= w_alu_grant || w_lsu_grant;
            if (w_alu_grant || w_lsu_grant) begin
                rf_write_register <= w_win_req.rd;
                rf_write_data     <= w_win_req.data;
            end
        end
    end

`ifdef RF_WB_FWD_EN
    // Bypass the write in flight, since the regfile read still returns the old value this cycle.
    always_comb begin
        fwd_hit1  = rf_reg_write && (rf_write_register == fwd_rs1) && (fwd_rs1 != REG_ZERO);
        fwd_hit2  = rf_reg_write && (rf_write_register == fwd_rs2) && (fwd_rs2 != REG_ZERO);
        fwd_data1 = fwd_hit1 ? rf_write_data : '0;
        fwd_data2 = fwd_hit2 ? rf_write_data : '0;
    end
`endif
endmodule
